gg_slice_sequencer: RTL and testbench
=====================================

# gg_slice_sequencer

Controls the row-slice lattice parser `gg_parse_lattice_rowslice`. It admits one slice at a time: candidate byte-aligned slice starts from the NAL front end are forwarded as `slice_start`, and all further starts are gated until the matching `slice_end` returns. It counts the macroblocks the lattice triggers and produces one descriptor per slice for the row/picture controller. When a descriptor is pending and not yet accepted, it stalls the upstream bit feed.

## Interface
- `WIDTH`, 32: bits per word; must match the lattice parser.
- `BYTE_WIDTH`, `WIDTH/8`: byte lanes per word.
- `MAX_MBS`, 120: macroblocks per row; a slice with more is flagged as an error.
- `TIMEOUT_WORDS`, 4096: watchdog limit, in accepted words per slice.
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `word_valid`, in, 1: upstream presents a word this cycle.
- `in_ready`, out, 1: word accepted when `word_valid & in_ready`.
- `cand_start`, in, `BYTE_WIDTH`: candidate slice starts. Lane `BYTE_WIDTH-1` is the earliest byte.
- `slice_start`, out, `BYTE_WIDTH`: gated start, connected to the lattice.
- `slice_end`, in, `BYTE_WIDTH`: from the lattice.
- `mb_start`, in, `WIDTH`: from the lattice; one bit per macroblock trigger.
- `busy`, out, 1: a slice is in flight.
- `desc_valid`, out, 1: descriptor available.
- `desc_ready`, in, 1: consumer accepts the descriptor.
- `desc_mb_count`, out, `$clog2(MAX_MBS+1)+1`: macroblock count for the slice.
- `desc_words`, out, 16: accepted words from the start word to the end word, inclusive.
- `desc_end_lane`, out, `$clog2(BYTE_WIDTH)`: byte offset of the end within the final word; 0 is the earliest byte.
- `desc_err`, out, 2: bit0 = MB overflow; bit1 = watchdog timeout.

## Operation
- States: IDLE, BUSY. A separate descriptor register carries its own valid bit.
- `in_ready = !desc_valid | desc_ready` (combinational).
- A word is *accepted* when `word_valid & in_ready`. Nothing below happens on a cycle with no accepted word, and `slice_start` is 0 on such cycles.
- **IDLE:**
  - `slice_start` = only the earliest (highest-index) set lane of `cand_start`; all other lanes are dropped.
  - If a lane is issued: go to BUSY, `words` = 1, `mb` = popcount of `mb_start`.
- **BUSY:**
  - `words++` and `mb += popcount(mb_start)` on each accepted word.
  - `cand_start` lanes are masked, except lanes later (lower index) than a `slice_end` lane in the same word. The earliest such lane is issued: back-to-back slices.
  - On `slice_end` (earliest set lane e):
    - Load the descriptor: `mb`, `words`, `desc_end_lane` = `BYTE_WIDTH-1-e`, error bits.
    - Set `desc_valid`.
    - Go to IDLE, or stay in BUSY with counters reset if a new start was issued in the same word.
  - `slice_end` in IDLE is ignored.
- `mb_start` bits in the word carrying `slice_end` are all counted; the lattice emits none past the end.
- The MB count saturates at its maximum; `err[0]` is set once `mb > MAX_MBS`.
- `desc_valid` clears on `desc_valid & desc_ready`. A new descriptor may load in the same cycle; the new load wins.
- `busy` = (state == BUSY).

## Timing
- `slice_start` is combinational from `cand_start`, `slice_end`, state and `in_ready`, so the lattice sees it in the same word.
- The descriptor is registered: `desc_valid` rises the cycle after the accepted end word.
- No overwrite is possible: `in_ready` is 0 while a descriptor is unaccepted, so no new end word can be accepted.
- Reset values: state IDLE, counters 0, `desc_valid` 0, all `desc_*` 0, `busy` 0, `slice_start` 0, `in_ready` 1.
- Reset mid-slice drops the slice silently; no descriptor is produced.

## Configuration
- `GG_SLICE_WATCHDOG_EN` defined:
  - When `words` reaches `TIMEOUT_WORDS` in BUSY, emit a descriptor with `err[1]=1`, `desc_end_lane`=0 and the current counts.
  - Go to IDLE. Any later `slice_end` for that slice is ignored.
  - Timeout takes priority over a `slice_end` arriving in the same word.
- Undefined: no timeout logic; `err[1]` is tied to 0 and `words` saturates at 0xFFFF.

## Test plan
- **Single slice:** start lane 3 in word 0, end lane 1 in word 9, 5 `mb_start` bits total → one descriptor {mb=5, words=10, end_lane=2, err=0}; `desc_valid` high on the cycle after word 9.
- **Multiple candidates:** `cand_start`=4'b0110 in IDLE → `slice_start`=4'b0100. A candidate in word 3 while BUSY is masked.
- **Back-to-back:** `slice_end`=4'b1000 and `cand_start`=4'b0010 in the same word → `slice_start`=4'b0010, first descriptor end_lane=0, second slice counts start at words=1.
- **Backpressure:** `desc_ready`=0 for 5 cycles after a descriptor → `in_ready`=0 for those cycles and no counter changes. On the `desc_ready` pulse, `in_ready`=1 in the same cycle.
- **Overflow:** 121 `mb_start` bits with `MAX_MBS`=120 → `desc_err`=2'b01, mb=121.
- **Watchdog and reset:** with `GG_SLICE_WATCHDOG_EN`, `TIMEOUT_WORDS`=8 and no end → descriptor {words=8, err=2'b10}. A separate run asserts `reset` at word 4 → no descriptor and `busy`=0.

Source files
------------

// File: rtl/gg_slice_sequencer_if.sv
// Bundle between the slice sequencer and its neighbours: upstream word feed,
// lattice parser start/end/macroblock lines, and the per-slice descriptor.
interface gg_slice_sequencer_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MAX_MBS = 120
);
    localparam int unsigned BYTE_WIDTH = WIDTH / 8;
    localparam int unsigned MB_W       = $clog2(MAX_MBS + 1) + 1;
    localparam int unsigned LANE_W     = $clog2(BYTE_WIDTH);

    logic                  word_valid;
    logic                  in_ready;
    logic [BYTE_WIDTH-1:0] cand_start;
    logic [BYTE_WIDTH-1:0] slice_start;
    logic [BYTE_WIDTH-1:0] slice_end;
    logic [WIDTH-1:0]      mb_start;
    logic                  busy;
    logic                  desc_valid;
    logic                  desc_ready;
    logic [MB_W-1:0]       desc_mb_count;
    logic [15:0]           desc_words;
    logic [LANE_W-1:0]     desc_end_lane;
    logic [1:0]            desc_err;

    modport master (
        output word_valid, cand_start, slice_end, mb_start, desc_ready,
        input  in_ready, slice_start, busy, desc_valid, desc_mb_count,
               desc_words, desc_end_lane, desc_err
    );

    modport slave (
        input  word_valid, cand_start, slice_end, mb_start, desc_ready,
        output in_ready, slice_start, busy, desc_valid, desc_mb_count,
               desc_words, desc_end_lane, desc_err
    );
endinterface

// File: rtl/gg_slice_sequencer.sv
// Admits one slice at a time into the row-slice lattice and emits a descriptor per slice.
// Optional watchdog: define GG_SLICE_WATCHDOG_EN to end slices after TIMEOUT_WORDS words.
module gg_slice_sequencer #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned MAX_MBS       = 120,
    parameter int unsigned TIMEOUT_WORDS = 4096
) (
    input logic                 clk,
    input logic                 reset,
    gg_slice_sequencer_if.slave bus
);
    localparam int unsigned BYTE_WIDTH = WIDTH / 8;
    localparam int unsigned MB_W       = $clog2(MAX_MBS + 1) + 1;
    localparam int unsigned LANE_W     = $clog2(BYTE_WIDTH);
    localparam int unsigned WORDS_W    = 16;
    localparam int unsigned POP_W      = $clog2(WIDTH + 1);
    localparam int unsigned SUM_W      = ((MB_W > POP_W) ? MB_W : POP_W) + 1;
    localparam logic [MB_W-1:0]    MB_SAT    = '1;
    localparam logic [WORDS_W-1:0] WORDS_SAT = '1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                state, state_n;
    logic [WORDS_W-1:0]    words, words_n, words_inc;
    logic [MB_W-1:0]       mb, mb_n, mb_acc;
    logic [POP_W-1:0]      pop;
    logic [SUM_W-1:0]      mb_sum;
    logic                  in_ready_c, accept, timeout, mb_over;
    logic [BYTE_WIDTH-1:0] start_c, later_mask, late_cand;
    logic [LANE_W-1:0]     end_idx;
    logic                  load;
    logic [LANE_W-1:0]     ld_lane;
    logic [1:0]            ld_err;

    logic                  desc_valid_q;
    logic [MB_W-1:0]       desc_mb_q;
    logic [WORDS_W-1:0]    desc_words_q;
    logic [LANE_W-1:0]     desc_lane_q;
    logic [1:0]            desc_err_q;

    // Earliest byte is the highest lane index, so the last set bit seen wins.
    function automatic logic [BYTE_WIDTH-1:0] first_lane(input logic [BYTE_WIDTH-1:0] v);
        logic [BYTE_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < int'(BYTE_WIDTH); i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [LANE_W-1:0] first_idx(input logic [BYTE_WIDTH-1:0] v);
        logic [LANE_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(BYTE_WIDTH); i++) begin
            if (v[i]) r = LANE_W'(i);
        end
        return r;
    endfunction

    assign in_ready_c = !desc_valid_q || bus.desc_ready;
    assign accept     = bus.word_valid && in_ready_c && !reset;
    assign pop        = POP_W'($countones(bus.mb_start));
    assign mb_sum     = SUM_W'(mb) + SUM_W'(pop);
    assign mb_acc     = (mb_sum > SUM_W'(MB_SAT)) ? MB_SAT : MB_W'(mb_sum);
    assign mb_over    = (mb_acc > MB_W'(MAX_MBS));
    assign words_inc  = (words == WORDS_SAT) ? words : words + WORDS_W'(1);
    assign end_idx    = first_idx(bus.slice_end);
    assign late_cand  = bus.cand_start & later_mask;

    // Only candidates after the end byte of the current slice may restart.
    always_comb begin
        later_mask = '0;
        for (int i = 0; i < int'(BYTE_WIDTH); i++) begin
            later_mask[i] = (i < int'(end_idx));
        end
    end

`ifdef GG_SLICE_WATCHDOG_EN
    assign timeout = (state == BUSY) && (words_inc == WORDS_W'(TIMEOUT_WORDS));
`else
    logic unused_timeout_cfg;
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^WORDS_W'(TIMEOUT_WORDS);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            words <= '0;
            mb    <= '0;
        end else begin
            state <= state_n;
            words <= words_n;
            mb    <= mb_n;
        end
    end

    always_comb begin
        state_n = state;
        words_n = words;
        mb_n    = mb;
        start_c = '0;
        load    = 1'b0;
        ld_lane = '0;
        ld_err  = '0;
        if (accept) begin
            case (state)
                IDLE: begin
                    start_c = first_lane(bus.cand_start);
                    if (|bus.cand_start) begin
                        state_n = BUSY;
                        words_n = words_inc;
                        mb_n    = mb_acc;
                    end
                end
                BUSY: begin
                    words_n = words_inc;
                    mb_n    = mb_acc;
                    if (timeout) begin
                        load    = 1'b1;
                        ld_err  = {1'b1, mb_over};
                        state_n = IDLE;
                        words_n = '0;
                        mb_n    = '0;
                    end else if (|bus.slice_end) begin
                        load    = 1'b1;
                        ld_err  = {1'b0, mb_over};
                        ld_lane = LANE_W'(BYTE_WIDTH - 1) - end_idx;
                        start_c = first_lane(late_cand);
                        if (|late_cand) begin
                            words_n = WORDS_W'(1);
                            mb_n    = '0;
                        end else begin
                            state_n = IDLE;
                            words_n = '0;
                            mb_n    = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Descriptor register; a same-cycle load takes precedence over the pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            desc_valid_q <= 1'b0;
            desc_mb_q    <= '0;
            desc_words_q <= '0;
            desc_lane_q  <= '0;
            desc_err_q   <= '0;
        end else if (load) begin
            desc_valid_q <= 1'b1;
            desc_mb_q    <= mb_acc;
            desc_words_q <= words_inc;
            desc_lane_q  <= ld_lane;
            desc_err_q   <= ld_err;
        end else if (desc_valid_q && bus.desc_ready) begin
            desc_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready      = in_ready_c;
    assign bus.slice_start   = start_c;
    assign bus.busy          = (state == BUSY);
    assign bus.desc_valid    = desc_valid_q;
    assign bus.desc_mb_count = desc_mb_q;
    assign bus.desc_words    = desc_words_q;
    assign bus.desc_end_lane = desc_lane_q;
    assign bus.desc_err      = desc_err_q;
endmodule

// File: tb/tb_gg_slice_sequencer.sv
// Directed bench for gg_slice_sequencer: transaction-level slice model checked every cycle,
// plus hand-computed descriptor values for each scenario.
module tb_gg_slice_sequencer;
    localparam int TO_W    = 8;
    localparam int MAXMB   = 120;
`ifdef GG_SLICE_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk;
    logic reset;
    gg_slice_sequencer_if #(.WIDTH(32), .MAX_MBS(MAXMB)) bus ();

    gg_slice_sequencer #(
        .WIDTH(32), .MAX_MBS(MAXMB), .TIMEOUT_WORDS(TO_W)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ones(input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic int top_lane(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Slice model: true counts, saturated only when a descriptor is formed.
    bit m_busy = 0, m_dvalid = 0, started = 0;
    int m_words = 0, m_mb = 0;
    int m_dmb = 0, m_dwords = 0, m_dlane = 0, m_derr = 0;

    always @(negedge clk) begin
        int e, c, p;
        bit acc, exp_ir, to;
        logic [3:0] exp_ss;
        exp_ir = !m_dvalid || bus.desc_ready;
        acc    = bus.word_valid && exp_ir && !reset;
        p      = $countones(bus.mb_start);
        e      = top_lane(bus.slice_end);
        to     = 1'b0;
        exp_ss = '0;
        if (acc) begin
            if (!m_busy) begin
                c = top_lane(bus.cand_start);
                if (c >= 0) exp_ss[c] = 1'b1;
            end else begin
                to = WD && (m_words + 1 == TO_W);
                if (!to && e >= 0) begin
                    c = -1;
                    for (int i = 0; i < e; i++) if (bus.cand_start[i]) c = i;
                    if (c >= 0) exp_ss[c] = 1'b1;
                end
            end
        end
        if (started) begin
            check("in_ready", 32'(bus.in_ready), 32'(exp_ir));
            check("slice_start", 32'(bus.slice_start), 32'(exp_ss));
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("desc_valid", 32'(bus.desc_valid), 32'(m_dvalid));
            if (m_dvalid) begin
                check("desc_mb_count", 32'(bus.desc_mb_count), 32'(m_dmb));
                check("desc_words", 32'(bus.desc_words), 32'(m_dwords));
                check("desc_end_lane", 32'(bus.desc_end_lane), 32'(m_dlane));
                check("desc_err", 32'(bus.desc_err), 32'(m_derr));
            end
        end
        if (reset) begin
            started = 1;
            m_busy = 0; m_words = 0; m_mb = 0; m_dvalid = 0;
            m_dmb = 0; m_dwords = 0; m_dlane = 0; m_derr = 0;
        end else begin
            if (m_dvalid && bus.desc_ready) m_dvalid = 0;
            if (acc) begin
                if (!m_busy) begin
                    if (exp_ss != 0) begin
                        m_busy = 1; m_words = 1; m_mb = p;
                    end
                end else begin
                    m_words++;
                    m_mb += p;
                    if (to || e >= 0) begin
                        m_dvalid = 1;
                        m_dmb    = (m_mb > 255) ? 255 : m_mb;
                        m_dwords = (m_words > 65535) ? 65535 : m_words;
                        m_dlane  = to ? 0 : 3 - e;
                        m_derr   = (to ? 2 : 0) | ((m_mb > MAXMB) ? 1 : 0);
                        if (!to && exp_ss != 0) begin
                            m_words = 1; m_mb = 0;
                        end else begin
                            m_busy = 0;
                        end
                    end
                end
            end
        end
    end

    logic [3:0] last_ss;
    logic       last_ir;

    // One word per call; returns one time unit after the clock edge that consumed it.
    task automatic step(input logic v, input logic [3:0] cand, input logic [3:0] send, input int nmb);
        bus.word_valid = v;
        bus.cand_start = cand;
        bus.slice_end  = send;
        bus.mb_start   = ones(nmb);
        @(negedge clk);
        last_ss = bus.slice_start;
        last_ir = bus.in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic check_desc(input string tag, input int mbc, input int w, input int lane, input int err);
        check({tag, "_valid"}, 32'(bus.desc_valid), 32'd1);
        check({tag, "_mb"}, 32'(bus.desc_mb_count), 32'(mbc));
        check({tag, "_words"}, 32'(bus.desc_words), 32'(w));
        check({tag, "_lane"}, 32'(bus.desc_end_lane), 32'(lane));
        check({tag, "_err"}, 32'(bus.desc_err), 32'(err));
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        bus.word_valid = 1'b0;
        bus.cand_start = '0;
        bus.slice_end  = '0;
        bus.mb_start   = '0;
        bus.desc_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_desc_valid", 32'(bus.desc_valid), 32'd0);
        check("rst_desc_mb", 32'(bus.desc_mb_count), 32'd0);
        check("rst_desc_words", 32'(bus.desc_words), 32'd0);
        check("rst_desc_lane", 32'(bus.desc_end_lane), 32'd0);
        check("rst_desc_err", 32'(bus.desc_err), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_slice_start", 32'(bus.slice_start), 32'd0);

        // Single slice: start lane 3 in word 0, end lane 1 in word 9, 5 mb bits.
        step(1, 4'b1000, 4'b0000, 1);
        check("t1_ss", 32'(last_ss), 32'b1000);
        check("t1_busy", 32'(bus.busy), 32'd1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 2);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        repeat (3) step(1, 0, 0, 0);
        step(1, 4'b0000, 4'b0010, 1);
`ifndef GG_SLICE_WATCHDOG_EN
        check_desc("t1", 5, 10, 2, 0);
        check("t1_model_mb", 32'(m_dmb), 32'd5);
        check("t1_model_words", 32'(m_dwords), 32'd10);
        check("t1_busy_after", 32'(bus.busy), 32'd0);
`endif

        // Multiple candidates; unaccepted word and masked candidate while busy.
        step(1, 0, 0, 0);
        step(1, 4'b0110, 0, 0);
        check("t2_ss", 32'(last_ss), 32'b0100);
        step(1, 0, 0, 0);
        step(0, 4'b1000, 4'b0001, 3);
        check("t2_novalid_ss", 32'(last_ss), 32'd0);
        step(1, 4'b1000, 0, 0);
        check("t2_masked_ss", 32'(last_ss), 32'd0);
        check("t2_busy", 32'(bus.busy), 32'd1);
        step(1, 0, 4'b0001, 0);
        check_desc("t2", 0, 4, 3, 0);

        // Back-to-back slices in one word.
        step(1, 4'b1000, 0, 2);
        step(1, 0, 0, 1);
        step(1, 4'b0010, 4'b1000, 1);
        check("t3_ss", 32'(last_ss), 32'b0010);
        check_desc("t3a", 4, 3, 0, 0);
        check("t3_busy", 32'(bus.busy), 32'd1);
        step(1, 0, 0, 2);
        step(1, 0, 4'b0100, 0);
        check_desc("t3b", 2, 3, 1, 0);
        check("t3_model_words", 32'(m_dwords), 32'd3);

        // Backpressure: descriptor held, upstream stalled.
        step(1, 4'b0001, 0, 0);
        check("t4_ss", 32'(last_ss), 32'b0001);
        bus.desc_ready = 1'b0;
        step(1, 0, 4'b0001, 0);
        check_desc("t4a", 0, 2, 3, 0);
        repeat (5) begin
            step(1, 4'b1000, 0, 3);
            check("t4_stall_ir", 32'(last_ir), 32'd0);
            check("t4_stall_ss", 32'(last_ss), 32'd0);
            check("t4_stall_busy", 32'(bus.busy), 32'd0);
        end
        bus.desc_ready = 1'b1;
        step(1, 4'b1000, 0, 1);
        check("t4_pulse_ir", 32'(last_ir), 32'd1);
        check("t4_pulse_ss", 32'(last_ss), 32'b1000);
        check("t4_pulse_dv", 32'(bus.desc_valid), 32'd0);
        step(1, 0, 4'b0001, 0);
        check_desc("t4b", 1, 2, 3, 0);

        // Overflow: 121 macroblocks, then exactly 120.
        step(1, 4'b1000, 0, 32);
        step(1, 0, 0, 32);
        step(1, 0, 0, 32);
        step(1, 0, 4'b0001, 25);
        check_desc("t5a", 121, 4, 3, 1);
        check("t5_model_mb", 32'(m_dmb), 32'd121);
        step(1, 4'b1000, 0, 32);
        step(1, 0, 0, 32);
        step(1, 0, 0, 32);
        step(1, 0, 4'b0001, 24);
        check_desc("t5b", 120, 4, 3, 0);

        // Long slice: watchdog fires at word 8, otherwise ends normally at word 12.
        step(1, 4'b1000, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            step(1, 0, 0, 0);
`ifdef GG_SLICE_WATCHDOG_EN
            if (i == 7) begin
                check_desc("t6_wd", 0, 8, 0, 2);
                check("t6_wd_busy", 32'(bus.busy), 32'd0);
            end
`endif
        end
        step(1, 0, 4'b0100, 0);
`ifdef GG_SLICE_WATCHDOG_EN
        check("t6_late_end_dv", 32'(bus.desc_valid), 32'd0);
        check("t6_late_end_busy", 32'(bus.busy), 32'd0);
`else
        check_desc("t6", 0, 12, 1, 0);
`endif

        // Watchdog versus end-plus-restart in the same word.
        step(1, 4'b1000, 0, 0);
        repeat (6) step(1, 0, 0, 0);
        step(1, 4'b0001, 4'b0100, 0);
`ifdef GG_SLICE_WATCHDOG_EN
        check("t7_ss", 32'(last_ss), 32'd0);
        check_desc("t7", 0, 8, 0, 2);
`else
        check("t7_ss", 32'(last_ss), 32'b0001);
        check_desc("t7", 0, 8, 1, 0);
`endif
        step(1, 0, 4'b0001, 0);

        // Macroblock count saturation on a 10-word slice.
        step(1, 4'b1000, 0, 32);
        repeat (8) step(1, 0, 0, 32);
        step(1, 0, 4'b0001, 32);
`ifndef GG_SLICE_WATCHDOG_EN
        check_desc("t8_sat", 255, 10, 3, 1);
`endif

        // Reset mid-slice drops the slice.
        step(1, 4'b1000, 0, 1);
        repeat (3) step(1, 0, 0, 1);
        reset = 1'b1;
        step(1, 0, 4'b0001, 1);
        check("t9_rst_ss", 32'(last_ss), 32'd0);
        reset = 1'b0;
        check("t9_busy", 32'(bus.busy), 32'd0);
        check("t9_dv", 32'(bus.desc_valid), 32'd0);
        check("t9_ir", 32'(bus.in_ready), 32'd1);
        repeat (2) step(1, 0, 0, 0);
        check("t9_dv_later", 32'(bus.desc_valid), 32'd0);
        check("t9_busy_later", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
